// File: rtl/rle_vli_symbolizer_pkg.sv
// Shared types, constants and width helpers for the run/size/VLI symbolizer.
package rle_vli_symbolizer_pkg;

    localparam int unsigned RUN_W    = 4;
    localparam int unsigned RUN_MAX  = 15;
    localparam int unsigned ZRL_RUN  = 15;
    localparam int unsigned ZRL_SIZE = 0;
    localparam int unsigned EOB_RUN  = 0;
    localparam int unsigned EOB_SIZE = 0;

    function automatic int unsigned size_w(input int unsigned data_width);
        return $clog2(data_width + 1);
    endfunction

    function automatic int unsigned vli_w(input int unsigned data_width);
        return data_width;
    endfunction

    function automatic int unsigned comp_w(input int unsigned num_comp);
        return (num_comp > 1) ? $clog2(num_comp) : 1;
    endfunction

    // Enough bits for the largest number of pending ZRLs inside one block.
    function automatic int unsigned zrl_w(input int unsigned block_len);
        int unsigned w;
        w = $clog2((block_len - 2) / 16 + 1);
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic [1:0] {
        ST_DC,
        ST_AC,
        ST_ZRL_FLUSH
    } rle_state_t;

    // Symbol layout for the default configuration (DATA_WIDTH=11, NUM_COMP=3).
    localparam int unsigned DEF_DATA_WIDTH = 11;
    localparam int unsigned DEF_NUM_COMP   = 3;

    typedef struct packed {
        logic                              is_dc;
        logic [comp_w(DEF_NUM_COMP)-1:0]   comp;
        logic [RUN_W-1:0]                  run;
        logic [size_w(DEF_DATA_WIDTH)-1:0] size;
        logic [vli_w(DEF_DATA_WIDTH)-1:0]  vli;
        logic                              last;
    } rle_sym_t;

endpackage

// File: rtl/rle_vli_symbolizer_vli_encode.sv
// Combinational JPEG magnitude category (size) and VLI bits of a signed value.
module vli_encode #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned SIZE_W = 4,
    parameter int unsigned VLI_W  = 11
) (
    input  logic [WIDTH-1:0]  value,
    output logic [SIZE_W-1:0] size,
    output logic [VLI_W-1:0]  vli
);

    logic [WIDTH-1:0] mag;
    logic [VLI_W-1:0] src;

    // Size is the bit length of |value|; negative values send (value-1) in size bits.
    always_comb begin
        mag  = value[WIDTH-1] ? (~value + 1'b1) : value;
        size = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (mag[i]) begin
                size = SIZE_W'(i + 1);
            end
        end
        // Only the low VLI_W bits of (value-1) are ever transmitted.
        src = value[VLI_W-1:0] - VLI_W'(value[WIDTH-1]);
        vli = '0;
        for (int unsigned i = 0; i < VLI_W; i++) begin
            if (32'(size) > i) begin
                vli[i] = src[i];
            end
        end
    end

endmodule

// File: rtl/rle_vli_symbolizer.sv
// Zig-zag coefficient stream to JPEG run/size/VLI symbols with DC prediction.
module rle_vli_symbolizer
    import rle_vli_symbolizer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned NUM_COMP   = 3,
    parameter int unsigned BLOCK_LEN  = 64,
    localparam int unsigned COMP_W    = comp_w(NUM_COMP),
    localparam int unsigned SIZE_W    = size_w(DATA_WIDTH),
    localparam int unsigned VLI_W     = vli_w(DATA_WIDTH),
    localparam int unsigned SYM_W     = 1 + COMP_W + RUN_W + SIZE_W + VLI_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_coef,
    input  logic [COMP_W-1:0]     in_comp,
    input  logic                  restart,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SYM_W-1:0]      out_sym
);

    localparam int unsigned IDX_W = $clog2(BLOCK_LEN);
    localparam int unsigned ZP_W  = zrl_w(BLOCK_LEN);

    typedef struct packed {
        logic              is_dc;
        logic [COMP_W-1:0] comp;
        logic [RUN_W-1:0]  run;
        logic [SIZE_W-1:0] size;
        logic [VLI_W-1:0]  vli;
        logic              last;
    } sym_t;

    function automatic sym_t mk_sym(input logic is_dc, input logic [COMP_W-1:0] comp,
                                    input logic [RUN_W-1:0] run, input logic [SIZE_W-1:0] size,
                                    input logic [VLI_W-1:0] vli, input logic last);
        sym_t s;
        s.is_dc = is_dc;
        s.comp  = comp;
        s.run   = run;
        s.size  = size;
        s.vli   = vli;
        s.last  = last;
        return s;
    endfunction

    rle_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [ZP_W-1:0]       zrl_q, zrl_d;
    logic [COMP_W-1:0]     comp_q, comp_d;
    sym_t                  held_q, held_d;
    sym_t                  sym_q, sym_d;
    logic                  valid_q, valid_d;
    logic                  ready_en_q;
    logic [DATA_WIDTH-1:0] pred_q [NUM_COMP];

    logic [DATA_WIDTH-1:0] pred_sel;
    logic [DATA_WIDTH:0]   coef_ext;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH:0]   enc_in;
    logic [SIZE_W-1:0]     enc_size;
    logic [VLI_W-1:0]      enc_vli;
    logic                  out_free;
    logic                  accept;
    logic                  is_last;
    logic                  coef_zero;
    logic [IDX_W-1:0]      idx_next;
    sym_t                  zrl_sym;

    // Select the predictor of the incoming component; a restart in the same cycle zeroes it.
    always_comb begin
        pred_sel = '0;
        for (int unsigned c = 0; c < NUM_COMP; c++) begin
            if (in_comp == COMP_W'(c)) begin
                pred_sel = pred_q[c];
            end
        end
        coef_ext = {in_coef[DATA_WIDTH-1], in_coef};
        diff     = coef_ext - (restart ? '0 : {pred_sel[DATA_WIDTH-1], pred_sel});
        enc_in   = (state_q == ST_DC) ? diff : coef_ext;
    end

    vli_encode #(
        .WIDTH  (DATA_WIDTH + 1),
        .SIZE_W (SIZE_W),
        .VLI_W  (VLI_W)
    ) u_vli_encode (
        .value (enc_in),
        .size  (enc_size),
        .vli   (enc_vli)
    );

    assign out_free  = !valid_q || out_ready;
    assign in_ready  = ready_en_q && out_free && (state_q != ST_ZRL_FLUSH);
    assign accept    = in_valid && in_ready;
    assign is_last   = (idx_q == IDX_W'(BLOCK_LEN - 1));
    assign coef_zero = (in_coef == '0);
    assign idx_next  = is_last ? '0 : idx_q + 1'b1;
    assign zrl_sym   = mk_sym(1'b0, comp_q, RUN_W'(ZRL_RUN), SIZE_W'(ZRL_SIZE), '0, 1'b0);
    assign out_valid = valid_q;
    assign out_sym   = sym_q;

    // Next-state, run/ZRL bookkeeping and output register load decisions.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = run_q;
        zrl_d   = zrl_q;
        comp_d  = comp_q;
        held_d  = held_q;
        sym_d   = sym_q;
        valid_d = valid_q && !out_ready;
        case (state_q)
            ST_DC: begin
                if (accept) begin
                    state_d = ST_AC;
                    idx_d   = idx_next;
                    comp_d  = in_comp;
                    run_d   = '0;
                    zrl_d   = '0;
                    valid_d = 1'b1;
                    sym_d   = mk_sym(1'b1, in_comp, '0, enc_size, enc_vli, 1'b0);
                end
            end
            ST_AC: begin
                if (accept) begin
                    idx_d = idx_next;
                    if (coef_zero && !is_last) begin
                        if (run_q == RUN_W'(RUN_MAX)) begin
                            run_d = '0;
                            zrl_d = zrl_q + 1'b1;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else if (coef_zero) begin
                        state_d = ST_DC;
                        run_d   = '0;
                        zrl_d   = '0;
                        valid_d = 1'b1;
                        sym_d   = mk_sym(1'b0, comp_q, RUN_W'(EOB_RUN), SIZE_W'(EOB_SIZE), '0, 1'b1);
                    end else if (zrl_q == '0) begin
                        run_d   = '0;
                        valid_d = 1'b1;
                        sym_d   = mk_sym(1'b0, comp_q, run_q, enc_size, enc_vli, is_last);
                        if (is_last) begin
                            state_d = ST_DC;
                        end
                    end else begin
                        // First ZRL goes out on the accepting edge; the coefficient waits in held.
                        state_d = ST_ZRL_FLUSH;
                        held_d  = mk_sym(1'b0, comp_q, run_q, enc_size, enc_vli, is_last);
                        run_d   = '0;
                        zrl_d   = zrl_q - 1'b1;
                        valid_d = 1'b1;
                        sym_d   = zrl_sym;
                    end
                end
            end
            ST_ZRL_FLUSH: begin
                if (out_free) begin
                    valid_d = 1'b1;
                    if (zrl_q != '0) begin
                        zrl_d = zrl_q - 1'b1;
                        sym_d = zrl_sym;
                    end else begin
                        sym_d   = held_q;
                        state_d = held_q.last ? ST_DC : ST_AC;
                    end
                end
            end
            default: begin
                state_d = ST_DC;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_DC;
            idx_q      <= '0;
            run_q      <= '0;
            zrl_q      <= '0;
            comp_q     <= '0;
            held_q     <= '0;
            sym_q      <= '0;
            valid_q    <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            run_q      <= run_d;
            zrl_q      <= zrl_d;
            comp_q     <= comp_d;
            held_q     <= held_d;
            sym_q      <= sym_d;
            valid_q    <= valid_d;
            ready_en_q <= 1'b1;
        end
    end

    // DC predictor file: restart clears all entries, an accepted DC then overwrites its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_COMP; c++) begin
                pred_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_COMP; c++) begin
                if (restart) begin
                    pred_q[c] <= '0;
                end
                if (accept && (state_q == ST_DC) && (in_comp == COMP_W'(c))) begin
                    pred_q[c] <= in_coef;
                end
            end
        end
    end

endmodule

// File: tb/tb_rle_vli_symbolizer.sv
// Directed bench for rle_vli_symbolizer with a block-level symbol model.
module tb_rle_vli_symbolizer;
    import rle_vli_symbolizer_pkg::*;

    localparam int BL = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_coef = '0;
    logic [1:0]  in_comp = '0;
    logic        restart = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [22:0] out_sym;

    rle_vli_symbolizer #(
        .DATA_WIDTH (11),
        .NUM_COMP   (3),
        .BLOCK_LEN  (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .in_comp   (in_comp),
        .restart   (restart),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym)
    );

    always #5 clk = ~clk;

    int       n_vec  = 0;
    int       n_fail = 0;
    bit       stall_en = 1'b0;
    int       blk [BL];
    int       wt [BL];
    int       mpred [3];
    rle_sym_t exp_q [$];
    rle_sym_t obs [$];
    rle_sym_t got;
    rle_sym_t held_obs;
    bit       stable_pending = 1'b0;
    int       base;

    assign got = out_sym;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Model: size is the bit length of |v|; negative values map to v + 2^size - 1.
    function automatic void vli_model(input int v, output int sz, output int vl);
        int m;
        m  = (v < 0) ? -v : v;
        sz = 0;
        while (m > 0) begin
            sz++;
            m = m >> 1;
        end
        vl = (v >= 0) ? v : v + (1 << sz) - 1;
    endfunction

    function automatic rle_sym_t mk_sym(input bit dc, input int comp, input int run, input int v, input bit last);
        rle_sym_t s;
        int sz, vl;
        vli_model(v, sz, vl);
        s.is_dc = dc;
        s.comp  = comp[1:0];
        s.run   = run[3:0];
        s.size  = sz[3:0];
        s.vli   = vl[10:0];
        s.last  = last;
        return s;
    endfunction

    function automatic rle_sym_t lit(input bit dc, input int comp, input int run, input int size, input int vli, input bit last);
        rle_sym_t s;
        s.is_dc = dc;
        s.comp  = comp[1:0];
        s.run   = run[3:0];
        s.size  = size[3:0];
        s.vli   = vli[10:0];
        s.last  = last;
        return s;
    endfunction

    // Expected symbols of the first n coefficients of blk[] for one block.
    task automatic expect_block(input int comp, input int n, input bit rs);
        int run;
        if (rs) mpred = '{0, 0, 0};
        exp_q.push_back(mk_sym(1'b1, comp, 0, blk[0] - mpred[comp], 1'b0));
        mpred[comp] = blk[0];
        run = 0;
        for (int k = 1; k < n; k++) begin
            if (blk[k] == 0) begin
                if (k == BL - 1) exp_q.push_back(mk_sym(1'b0, comp, 0, 0, 1'b1));
                else run++;
            end else begin
                while (run >= 16) begin
                    exp_q.push_back(mk_sym(1'b0, comp, 15, 0, 1'b0));
                    run -= 16;
                end
                exp_q.push_back(mk_sym(1'b0, comp, run, blk[k], k == BL - 1));
                run = 0;
            end
        end
    endtask

    task automatic send(input int coef, input int comp, input bit rs, output int waited);
        in_valid = 1'b1;
        in_coef  = coef[10:0];
        in_comp  = comp[1:0];
        restart  = rs;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 2000) begin
                n_vec++;
                n_fail++;
                $display("FAIL in_ready_timeout: got waited %0d want accept", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic run_block(input int comp, input int n, input bit rs);
        int w;
        expect_block(comp, n, rs);
        for (int k = 0; k < n; k++) begin
            send(blk[k], comp, (k == 0) && rs, w);
            wt[k] = w;
        end
    endtask

    task automatic clear_blk();
        for (int k = 0; k < BL; k++) blk[k] = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d symbols outstanding want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Optional random backpressure on the output side.
    always @(posedge clk) begin
        #1;
        out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: every output handshake against the model, hold-stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_out_sym", {9'd0, out_sym}, 32'd0);
            stable_pending = 1'b0;
        end else begin
            if (stable_pending) begin
                check("stall_hold", {8'd0, out_valid, got}, {8'd0, 1'b1, held_obs});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_symbol", {9'd0, got}, 32'hFFFF_FFFF);
                end else begin
                    check("symbol", {9'd0, got}, {9'd0, exp_q.pop_front()});
                end
                obs.push_back(got);
            end
            stable_pending = out_valid && !out_ready;
            held_obs = got;
        end
    end

    initial begin
        mpred = '{0, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Block 1: comp0 DC=5, AC1=-3
        base = obs.size();
        clear_blk();
        blk[0] = 5;
        blk[1] = -3;
        run_block(0, BL, 1'b0);
        check("b1_ac1_no_wait", wt[1], 0);
        drain();
        check("b1_dc_lit", {9'd0, obs[base]},     {9'd0, lit(1, 0, 0, 3, 5, 0)});
        check("b1_ac_lit", {9'd0, obs[base + 1]}, {9'd0, lit(0, 0, 0, 2, 0, 0)});
        check("b1_eob_lit", {9'd0, obs[base + 2]}, {9'd0, lit(0, 0, 0, 0, 0, 1)});

        // Block 2: comp0 DC=2, comp1 DC=2, restart, comp0 DC=2
        base = obs.size();
        clear_blk();
        blk[0] = 2;
        run_block(0, BL, 1'b0);
        run_block(1, BL, 1'b0);
        restart = 1'b1;
        mpred = '{0, 0, 0};
        @(posedge clk);
        #1;
        restart = 1'b0;
        run_block(0, BL, 1'b0);
        drain();
        check("b2_dc0_lit", {9'd0, obs[base]},     {9'd0, lit(1, 0, 0, 2, 0, 0)});
        check("b2_dc1_lit", {9'd0, obs[base + 2]}, {9'd0, lit(1, 1, 0, 2, 2, 0)});
        check("b2_rst_lit", {9'd0, obs[base + 4]}, {9'd0, lit(1, 0, 0, 2, 2, 0)});

        // Block 3: comp1, AC41=1 after 40 zeros
        base = obs.size();
        clear_blk();
        blk[41] = 1;
        run_block(1, BL, 1'b0);
        check("b3_ready_low", wt[42], 2);
        drain();
        check("b3_zrl_lit", {9'd0, obs[base + 1]}, {9'd0, lit(0, 1, 15, 0, 0, 0)});
        check("b3_ac_lit",  {9'd0, obs[base + 3]}, {9'd0, lit(0, 1, 8, 1, 1, 0)});
        check("b3_count", obs.size() - base, 5);

        // Block 4: comp2, AC63=7 after 62 zeros
        base = obs.size();
        clear_blk();
        blk[0] = -4;
        blk[63] = 7;
        run_block(2, BL, 1'b0);
        drain();
        check("b4_last_lit", {9'd0, obs[base + 4]}, {9'd0, lit(0, 2, 14, 3, 7, 1)});
        check("b4_count", obs.size() - base, 5);

        // Block 4b: immediately after a last symbol behind three ZRLs
        clear_blk();
        blk[0] = 1;
        blk[63] = 7;
        run_block(0, BL, 1'b0);
        clear_blk();
        blk[0] = 3;
        run_block(1, BL, 1'b0);
        check("b4b_dc_wait", wt[0], 3);
        drain();

        // Block 5: extremes, nonzero AC16, trailing zeros; random output stalls
        stall_en = 1'b1;
        base = obs.size();
        clear_blk();
        blk[0] = 1023;
        blk[1] = -1024;
        blk[2] = 1023;
        blk[4] = -1;
        blk[16] = 3;
        run_block(0, BL, 1'b0);
        drain();
        check("b5_count", obs.size() - base, 6);
        clear_blk();
        blk[0] = -1024;
        blk[5] = 100;
        blk[30] = -17;
        run_block(2, BL, 1'b1);
        drain();
        stall_en = 1'b0;
        drain();

        // Block 6: reset after 20 coefficients, then a fresh block
        clear_blk();
        blk[0] = 9;
        run_block(0, 20, 1'b0);
        drain();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mpred = '{0, 0, 0};
        @(posedge clk);
        #1;
        base = obs.size();
        clear_blk();
        blk[0] = -1;
        blk[1] = 1;
        blk[63] = -2;
        run_block(0, BL, 1'b0);
        drain();
        check("b6_dc_lit", {9'd0, obs[base]},     {9'd0, lit(1, 0, 0, 1, 0, 0)});
        check("b6_ac_lit", {9'd0, obs[base + 1]}, {9'd0, lit(0, 0, 0, 1, 1, 0)});
        check("b6_last_lit", {9'd0, obs[base + 5]}, {9'd0, lit(0, 0, 13, 2, 1, 1)});
        check("b6_count", obs.size() - base, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
